doodle_jump_ctrl: RTL and testbench

DOODLE_JUMP_CTRL -- requirements
Module: doodle_jump_ctrl

---
 rtl/doodle_pkg.sv | 13 +
 rtl/doodle_score.sv | 47 ++++
 rtl/doodle_jump_ctrl.sv | 141 ++++++++++++++
 tb/tb_doodle_jump_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/doodle_pkg.sv
// Shared state encoding and default widths for the doodle jump controller.
package doodle_pkg;
  localparam int JW_DEF = 8;
  localparam int HW_DEF = 10;
  localparam int SW_DEF = 16;

  typedef enum logic [3:0] {
    ST_I    = 4'b0001,
    ST_UP   = 4'b0010,
    ST_DOWN = 4'b0100,
    ST_DONE = 4'b1000
  } state_t;
endpackage

// File: rtl/doodle_score.sv
// Score, peak-height and high-score tracking for one game session.
module doodle_score
  import doodle_pkg::*;
#(
  parameter int HW = HW_DEF,
  parameter int SW = SW_DEF
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          clear,
  input  logic          climb,
  input  logic [HW-1:0] height_new,
  input  logic          game_over,
  output logic [SW-1:0] Score,
  output logic [SW-1:0] HiScore
);

  logic [SW-1:0] score_q, hiscore_q;
  logic [HW-1:0] peak_q;

  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    return (&v) ? v : v + SW'(1);
  endfunction

  // Points are earned only for height above the best reached this game.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      score_q   <= '0;
      peak_q    <= '0;
      hiscore_q <= '0;
    end else begin
      if (clear) begin
        score_q <= '0;
        peak_q  <= '0;
      end else if (climb && (height_new > peak_q)) begin
        peak_q  <= height_new;
        score_q <= sat_inc(score_q);
      end
      if (game_over && (score_q > hiscore_q))
        hiscore_q <= score_q;
    end
  end

  assign Score   = score_q;
  assign HiScore = hiscore_q;

endmodule

// File: rtl/doodle_jump_ctrl.sv
// Jump/fall game controller: one-hot FSM driving jump progress, height and
// fall speed, with scoring delegated to doodle_score.
module doodle_jump_ctrl
  import doodle_pkg::*;
#(
  parameter int JW           = JW_DEF,
  parameter int HW           = HW_DEF,
  parameter int SW           = SW_DEF,
  parameter int GRAVITY_MODE = 0,
  parameter int MAX_FALL     = 4
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic          Ack,
  input  logic          Tick,
  input  logic [JW-1:0] Jin,
  input  logic          Land,
  input  logic          Boost,
  output logic [JW-1:0] J,
  output logic [JW-1:0] Curr,
  output logic [HW-1:0] Height,
  output logic [SW-1:0] Score,
  output logic [SW-1:0] HiScore,
  output logic          q_I,
  output logic          q_Up,
  output logic          q_Down,
  output logic          q_Done
);

  state_t        state_q;
  logic [JW-1:0] j_q, curr_q, fall_step_q;
  logic [HW-1:0] height_q, height_inc;
  logic [JW-1:0] jin_min1, jin_boost;
  logic          climb, game_over, game_clear;

  function automatic logic [HW-1:0] sat_inc_h(input logic [HW-1:0] v);
    return (&v) ? v : v + HW'(1);
  endfunction

  function automatic logic [JW-1:0] sat_dbl_j(input logic [JW-1:0] v);
    return v[JW-1] ? '1 : {v[JW-2:0], 1'b0};
  endfunction

  function automatic logic [HW-1:0] sub_floor_h(input logic [HW-1:0] v,
                                                input logic [JW-1:0] s);
    logic [HW+JW-1:0] vw, sw, dw;
    vw = {{JW{1'b0}}, v};
    sw = {{HW{1'b0}}, s};
    dw = vw - sw;
    return (vw > sw) ? dw[HW-1:0] : '0;
  endfunction

  function automatic logic [JW-1:0] sub_floor_j(input logic [JW-1:0] v,
                                                input logic [JW-1:0] s);
    return (v > s) ? v - s : '0;
  endfunction

  assign jin_min1   = (Jin == '0) ? JW'(1) : Jin;
  assign jin_boost  = sat_dbl_j(Jin);
  assign height_inc = sat_inc_h(height_q);

  assign game_clear = (state_q == ST_I);
  assign climb      = (state_q == ST_UP) && Tick && (curr_q != j_q);
  assign game_over  = (state_q == ST_DOWN) && Tick && !Land && (height_q == '0);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= ST_I;
      j_q         <= '0;
      curr_q      <= '0;
      height_q    <= '0;
      fall_step_q <= '0;
    end else begin
      case (state_q)
        ST_I: begin
          j_q         <= jin_min1;
          curr_q      <= '0;
          height_q    <= '0;
          fall_step_q <= JW'(1);
          if (Start) state_q <= ST_UP;
        end
        ST_UP: begin
          if (Tick) begin
            if (curr_q == j_q) begin
              state_q <= ST_DOWN;
            end else begin
              curr_q   <= curr_q + JW'(1);
              height_q <= height_inc;
            end
          end
        end
        ST_DOWN: begin
          // Landing wins over both falling and running out of height.
          if (Tick) begin
            if (Land) begin
              state_q     <= ST_UP;
              curr_q      <= '0;
              fall_step_q <= JW'(1);
              j_q         <= Boost ? jin_boost : jin_min1;
            end else if (height_q == '0) begin
              state_q <= ST_DONE;
            end else begin
              height_q <= sub_floor_h(height_q, fall_step_q);
              curr_q   <= sub_floor_j(curr_q, fall_step_q);
              if (GRAVITY_MODE != 0 && fall_step_q < JW'(MAX_FALL))
                fall_step_q <= fall_step_q + JW'(1);
            end
          end
        end
        ST_DONE: begin
          if (Ack) state_q <= ST_I;
        end
        default: state_q <= ST_I;
      endcase
    end
  end

  doodle_score #(
    .HW(HW),
    .SW(SW)
  ) u_score (
    .Clk       (Clk),
    .Reset     (Reset),
    .clear     (game_clear),
    .climb     (climb),
    .height_new(height_inc),
    .game_over (game_over),
    .Score     (Score),
    .HiScore   (HiScore)
  );

  assign J      = j_q;
  assign Curr   = curr_q;
  assign Height = height_q;
  assign q_I    = (state_q == ST_I);
  assign q_Up   = (state_q == ST_UP);
  assign q_Down = (state_q == ST_DOWN);
  assign q_Done = (state_q == ST_DONE);

endmodule

// File: tb/tb_doodle_jump_ctrl.sv
// Bench for doodle_jump_ctrl: two gravity configurations driven in lockstep
// and compared every cycle against a rule-level game model.
module tb_doodle_jump_ctrl;

  logic       Clk = 1'b0;
  logic       Reset, Start, Ack, Tick, Land, Boost;
  logic [7:0] Jin;

  logic [7:0]  J_o[2], Curr_o[2];
  logic [9:0]  H_o[2];
  logic [15:0] S_o[2], Hi_o[2];
  logic        qi_o[2], qu_o[2], qd_o[2], qn_o[2];

  int checks   = 0;
  int failures = 0;

  // model: st 0=I 1=UP 2=DOWN 3=DONE
  int m_st[2], m_j[2], m_curr[2], m_h[2], m_score[2], m_hi[2], m_peak[2], m_fs[2];
  int m_mode[2] = '{0, 1};
  int m_maxf[2] = '{4, 2};

  always #5 Clk = ~Clk;

  doodle_jump_ctrl u_dut0 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack), .Tick(Tick), .Jin(Jin),
    .Land(Land), .Boost(Boost), .J(J_o[0]), .Curr(Curr_o[0]), .Height(H_o[0]),
    .Score(S_o[0]), .HiScore(Hi_o[0]), .q_I(qi_o[0]), .q_Up(qu_o[0]),
    .q_Down(qd_o[0]), .q_Done(qn_o[0])
  );

  doodle_jump_ctrl #(.GRAVITY_MODE(1), .MAX_FALL(2)) u_dut1 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack), .Tick(Tick), .Jin(Jin),
    .Land(Land), .Boost(Boost), .J(J_o[1]), .Curr(Curr_o[1]), .Height(H_o[1]),
    .Score(S_o[1]), .HiScore(Hi_o[1]), .q_I(qi_o[1]), .q_Up(qu_o[1]),
    .q_Down(qd_o[1]), .q_Done(qn_o[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_j[k] = 0; m_curr[k] = 0; m_h[k] = 0;
      m_score[k] = 0; m_hi[k] = 0; m_peak[k] = 0; m_fs[k] = 0;
    end
  endfunction

  function automatic void model_step(input int k);
    int jn;
    jn = int'(Jin);
    case (m_st[k])
      0: begin
        m_j[k] = (jn < 1) ? 1 : jn;
        m_curr[k] = 0; m_h[k] = 0; m_score[k] = 0; m_peak[k] = 0; m_fs[k] = 1;
        if (Start) m_st[k] = 1;
      end
      1: if (Tick) begin
        if (m_curr[k] == m_j[k]) m_st[k] = 2;
        else begin
          m_curr[k]++;
          if (m_h[k] < 1023) m_h[k]++;
          if (m_h[k] > m_peak[k]) begin
            m_peak[k] = m_h[k];
            if (m_score[k] < 65535) m_score[k]++;
          end
        end
      end
      2: if (Tick) begin
        if (Land) begin
          m_st[k] = 1; m_curr[k] = 0; m_fs[k] = 1;
          if (Boost) m_j[k] = (2 * jn > 255) ? 255 : 2 * jn;
          else       m_j[k] = (jn < 1) ? 1 : jn;
        end else if (m_h[k] == 0) begin
          m_st[k] = 3;
          if (m_score[k] > m_hi[k]) m_hi[k] = m_score[k];
        end else begin
          m_h[k]    = (m_h[k] > m_fs[k]) ? m_h[k] - m_fs[k] : 0;
          m_curr[k] = (m_curr[k] > m_fs[k]) ? m_curr[k] - m_fs[k] : 0;
          if (m_mode[k] == 1) m_fs[k] = (m_fs[k] + 1 > m_maxf[k]) ? m_maxf[k] : m_fs[k] + 1;
        end
      end
      default: if (Ack) m_st[k] = 0;
    endcase
  endfunction

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("J%0d", k),      32'(J_o[k]),    m_j[k]);
      check($sformatf("Curr%0d", k),   32'(Curr_o[k]), m_curr[k]);
      check($sformatf("Height%0d", k), 32'(H_o[k]),    m_h[k]);
      check($sformatf("Score%0d", k),  32'(S_o[k]),    m_score[k]);
      check($sformatf("HiScore%0d", k), 32'(Hi_o[k]),  m_hi[k]);
      check($sformatf("state%0d", k),  32'({qn_o[k], qd_o[k], qu_o[k], qi_o[k]}),
            32'(1) << m_st[k]);
    end
  endtask

  // Called just after a falling edge; returns just after the next one.
  task automatic cyc(input logic st, input logic ak, input logic tk,
                     input logic [7:0] jn, input logic ld, input logic bs);
    Start = st; Ack = ak; Tick = tk; Jin = jn; Land = ld; Boost = bs;
    @(posedge Clk);
    for (int k = 0; k < 2; k++) model_step(k);
    @(negedge Clk);
    compare_all();
  endtask

  task automatic async_reset();
    #2 Reset = 1'b0;
    #1 model_reset();
    compare_all();
    check("rst_qI", 32'(qi_o[0] & qi_o[1]), 32'd1);
    check("rst_H",  32'(H_o[0]) + 32'(H_o[1]), 32'd0);
    #1 Reset = 1'b1;
  endtask

  int exp_h1[3] = '{4, 2, 0};

  initial begin
    Reset = 1'b0; Start = 0; Ack = 0; Tick = 0; Land = 0; Boost = 0; Jin = 8'd0;
    model_reset();
    @(negedge Clk); @(negedge Clk);
    compare_all();
    Reset = 1'b1;

    // Plain game, no landing
    cyc(1, 0, 1, 8'd3, 0, 0);
    for (int i = 0; i < 12; i++) cyc(0, 0, 1, 8'd3, 0, 0);
    check("g1_score", 32'(S_o[0]), 32'd3);
    check("g1_hi",    32'(Hi_o[0]), 32'd3);
    check("g1_done",  32'(qn_o[0] & qn_o[1]), 32'd1);
    cyc(0, 1, 0, 8'd3, 0, 0);

    // Accelerating fall in the gravity-mode instance
    cyc(1, 0, 0, 8'd5, 0, 0);
    for (int i = 1; i <= 16; i++) begin
      cyc(0, 0, 1, 8'd5, 0, 0);
      if (i >= 7 && i <= 9) check($sformatf("fall_h%0d", i), 32'(H_o[1]), exp_h1[i-7]);
      if (i == 10) check("fall_done", 32'(qn_o[1]), 32'd1);
    end
    check("g2_hi", 32'(Hi_o[1]), 32'd5);
    cyc(0, 1, 0, 8'd0, 0, 0);

    // Lower-scoring game keeps the best score
    cyc(1, 0, 0, 8'd2, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 1, 8'd2, 0, 0);
    check("g3_score", 32'(S_o[0]), 32'd2);
    check("g3_hi",    32'(Hi_o[0]), 32'd5);
    cyc(0, 1, 0, 8'd0, 0, 0);

    // Reset in the middle of a jump
    cyc(1, 0, 0, 8'd4, 0, 0);
    cyc(0, 0, 1, 8'd4, 0, 0);
    cyc(0, 0, 1, 8'd4, 0, 0);
    async_reset();

    // Zero jump, boosted landing, frozen ticks
    cyc(0, 0, 0, 8'd0, 0, 0);
    check("jin0_J", 32'(J_o[0]), 32'd1);
    cyc(1, 0, 0, 8'd2, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 8'd2, 0, 0);
    cyc(0, 0, 1, 8'd2, 1, 1);
    check("boost_J", 32'(J_o[0]), 32'd4);
    cyc(0, 0, 1, 8'd2, 0, 0);
    cyc(0, 0, 1, 8'd2, 0, 0);
    for (int i = 0; i < 10; i++) cyc(1, 1, 0, 8'($urandom_range(0, 255)), 1, 1);
    check("pause_curr", 32'(Curr_o[0]), 32'd2);
    check("pause_h",    32'(H_o[0]), 32'd4);
    check("pause_up",   32'(qu_o[0]), 32'd1);
    cyc(0, 0, 1, 8'd2, 0, 0);
    cyc(0, 0, 1, 8'd2, 0, 0);
    check("peak_score", 32'(S_o[0]), 32'd6);
    check("peak_h",     32'(H_o[0]), 32'd6);
    cyc(0, 0, 1, 8'd2, 0, 0);
    cyc(0, 0, 1, 8'd200, 1, 1);
    check("boost_sat_J", 32'(J_o[0]), 32'd255);
    for (int i = 0; i < 600; i++) cyc(0, 0, 1, 8'd0, 0, 0);
    cyc(0, 1, 0, 8'd0, 0, 0);

    // Randomized play
    for (int n = 0; n < 4000; n++) begin
      logic [7:0] jr;
      int sel;
      sel = int'($urandom_range(0, 9));
      jr = (sel < 5) ? 8'($urandom_range(0, 7)) :
           (sel < 9) ? 8'($urandom_range(0, 20)) : 8'($urandom_range(0, 255));
      cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 3) != 0), jr,
          ($urandom_range(0, 5) == 0), $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 599) == 0) async_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
